ddr_local_port_arbiter: RTL and testbench

Two-requester round-robin arbiter in front of the DDR2 high-performance controller's local (Avalon, single-beat, 64-bit half-rate) interface. It shares the controller between two masters, e.g. the Nios II data master and a DMA engine. It tracks outstanding reads in an in-order tag FIFO so that each `local_rdata_valid` beat is routed back to the requester that issued it.

---
 rtl/ddr_local_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ddr_local_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_local_port_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_local_port_arbiter
// Two-requester round-robin arbiter in front of a DDR2 controller local
// (Avalon, single-beat) port. Outstanding reads are tracked in an in-order
// tag FIFO so every returning read beat is steered to the requester that
// issued it.
//
// Ports
//   clk, reset_n               half-rate clock, async active-low reset
//   rqN_read_req/write_req     requester commands, held until rqN_ready
//   rqN_addr/wdata/be          packed {cs,row,bank,col} address, write data
//   rqN_ready                  command accepted this cycle
//   rqN_rdata_valid, rq_rdata  read beat routed to requester N, shared data
//   local_*                    controller-side command/address/data
//   local_ready/init_done      controller handshake and init status
//   local_rdata_valid/rdata    controller read return
//   tag_count                  outstanding reads
//   tag_err                    sticky: read beat arrived with no tag pending
// ---------------------------------------------------------------------------
module ddr_local_port_arbiter #(
   parameter int DATA_BITS = 64,
   parameter int BE_BITS   = DATA_BITS / 8,
   parameter int CS_BITS   = 1,
   parameter int ROW_BITS  = 13,
   parameter int BANK_BITS = 2,
   parameter int COL_BITS  = 9,
   parameter int ADDR_BITS = CS_BITS + ROW_BITS + BANK_BITS + COL_BITS,
   parameter int TAG_DEPTH = 8,
   localparam int PTR_BITS = $clog2(TAG_DEPTH),
   localparam int CNT_BITS = PTR_BITS + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rq0_read_req,
   input  logic                 rq1_read_req,
   input  logic                 rq0_write_req,
   input  logic                 rq1_write_req,
   input  logic [ADDR_BITS-1:0] rq0_addr,
   input  logic [ADDR_BITS-1:0] rq1_addr,
   input  logic [DATA_BITS-1:0] rq0_wdata,
   input  logic [DATA_BITS-1:0] rq1_wdata,
   input  logic [BE_BITS-1:0]   rq0_be,
   input  logic [BE_BITS-1:0]   rq1_be,
   output logic                 rq0_ready,
   output logic                 rq1_ready,
   output logic                 rq0_rdata_valid,
   output logic                 rq1_rdata_valid,
   output logic [DATA_BITS-1:0] rq_rdata,
   output logic                 local_read_req,
   output logic                 local_write_req,
   output logic                 local_burstbegin,
   output logic                 local_size,
   output logic                 local_autopch_req,
   output logic [CS_BITS-1:0]   local_cs_addr,
   output logic [ROW_BITS-1:0]  local_row_addr,
   output logic [BANK_BITS-1:0] local_bank_addr,
   output logic [COL_BITS-1:0]  local_col_addr,
   output logic [DATA_BITS-1:0] local_wdata,
   output logic [BE_BITS-1:0]   local_be,
   input  logic                 local_ready,
   input  logic                 local_init_done,
   input  logic                 local_rdata_valid,
   input  logic [DATA_BITS-1:0] local_rdata,
   output logic [CNT_BITS-1:0]  tag_count,
   output logic                 tag_err
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   typedef struct packed {
      logic                 rd;
      logic                 wr;
      logic [ADDR_BITS-1:0] addr;
      logic [DATA_BITS-1:0] wdata;
      logic [BE_BITS-1:0]   be;
   } req_t;

   state_t              state_q, state_d;
   logic                rr_q;
   req_t                req [2];
   req_t                cur;
   logic [1:0]          pend;
   logic                k, granted, accept, push, pop, fifo_full, fifo_empty;

   logic                tag_mem [TAG_DEPTH];
   logic [PTR_BITS-1:0] wr_q, rd_q;
   logic [CNT_BITS-1:0] cnt_q;

   assign req[0] = {rq0_read_req, rq0_write_req, rq0_addr, rq0_wdata, rq0_be};
   assign req[1] = {rq1_read_req, rq1_write_req, rq1_addr, rq1_wdata, rq1_be};
   assign pend   = {rq1_read_req | rq1_write_req, rq0_read_req | rq0_write_req};

   assign granted = (state_q != IDLE);
   assign k       = (state_q == GNT1);
   assign cur     = req[k];

   // full is taken from the registered count: a pop in the same cycle does
   // not open a slot until the next cycle
   assign fifo_full  = (cnt_q == CNT_BITS'(TAG_DEPTH));
   assign fifo_empty = (cnt_q == '0);
   assign push       = local_read_req & local_ready;
   assign pop        = local_rdata_valid & ~fifo_empty;

   function automatic state_t gnt_st(input logic sel);
      return sel ? GNT1 : GNT0;
   endfunction

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) rr_q <= ~k;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (local_init_done && (pend != 2'b00)) begin
               if (pend == 2'b11) state_d = gnt_st(rr_q);
               else               state_d = gnt_st(pend[1]);
            end
         end
         GNT0, GNT1: begin
            if (accept) begin
               if (pend[~k])     state_d = gnt_st(~k);
               else if (pend[k]) state_d = gnt_st(k);
               else              state_d = IDLE;
            end else if (!pend[k]) begin
               // granted requester withdrew after its last accept; release
               // so the grant cannot park on an idle port
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      local_read_req  = 1'b0;
      local_write_req = 1'b0;
      local_cs_addr   = '0;
      local_row_addr  = '0;
      local_bank_addr = '0;
      local_col_addr  = '0;
      local_wdata     = '0;
      local_be        = '0;
      if (granted) begin
         local_read_req  = cur.rd & ~fifo_full;
         local_write_req = cur.wr & ~cur.rd;   // read wins if both held
         {local_cs_addr, local_row_addr, local_bank_addr, local_col_addr} = cur.addr;
         local_wdata     = cur.wdata;
         local_be        = cur.be;
      end
      local_burstbegin = local_read_req | local_write_req;
      accept           = local_burstbegin & local_ready;
      rq0_ready        = accept & ~k;
      rq1_ready        = accept & k;
   end

   assign local_size        = 1'b1;
   assign local_autopch_req = 1'b0;

   // ---------------- read tag FIFO ----------------
   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_q] <= k;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         tag_err <= 1'b0;
      end else begin
         if (push) wr_q <= wr_q + PTR_BITS'(1);
         if (pop)  rd_q <= rd_q + PTR_BITS'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_BITS'(1);
            2'b01:   cnt_q <= cnt_q - CNT_BITS'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (local_rdata_valid && fifo_empty) tag_err <= 1'b1;
      end
   end

   assign rq0_rdata_valid = pop & ~tag_mem[rd_q];
   assign rq1_rdata_valid = pop &  tag_mem[rd_q];
   assign rq_rdata        = local_rdata;
   assign tag_count       = cnt_q;

endmodule

// File: tb/tb_ddr_local_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_local_port_arbiter
// Scoreboard bench: requester drivers push each issued command into a
// per-requester expectation queue; a negedge monitor pops on rqN_ready and
// compares the controller-side command, tracks outstanding reads as a queue
// of owner ids, and checks routing of every returning read beat.
// ---------------------------------------------------------------------------
module tb_ddr_local_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rq0_read_req, rq1_read_req, rq0_write_req, rq1_write_req;
   logic [24:0] rq0_addr, rq1_addr;
   logic [63:0] rq0_wdata, rq1_wdata;
   logic [7:0]  rq0_be, rq1_be;
   logic        rq0_ready, rq1_ready, rq0_rdata_valid, rq1_rdata_valid;
   logic [63:0] rq_rdata;
   logic        local_read_req, local_write_req, local_burstbegin;
   logic        local_size, local_autopch_req;
   logic [0:0]  local_cs_addr;
   logic [12:0] local_row_addr;
   logic [1:0]  local_bank_addr;
   logic [8:0]  local_col_addr;
   logic [63:0] local_wdata;
   logic [7:0]  local_be;
   logic        local_ready, local_init_done, local_rdata_valid;
   logic [63:0] local_rdata;
   logic [3:0]  tag_count;
   logic        tag_err;

   always #5 clk = ~clk;

   ddr_local_port_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .rq0_read_req(rq0_read_req), .rq1_read_req(rq1_read_req),
      .rq0_write_req(rq0_write_req), .rq1_write_req(rq1_write_req),
      .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
      .rq0_wdata(rq0_wdata), .rq1_wdata(rq1_wdata),
      .rq0_be(rq0_be), .rq1_be(rq1_be),
      .rq0_ready(rq0_ready), .rq1_ready(rq1_ready),
      .rq0_rdata_valid(rq0_rdata_valid), .rq1_rdata_valid(rq1_rdata_valid),
      .rq_rdata(rq_rdata),
      .local_read_req(local_read_req), .local_write_req(local_write_req),
      .local_burstbegin(local_burstbegin), .local_size(local_size),
      .local_autopch_req(local_autopch_req),
      .local_cs_addr(local_cs_addr), .local_row_addr(local_row_addr),
      .local_bank_addr(local_bank_addr), .local_col_addr(local_col_addr),
      .local_wdata(local_wdata), .local_be(local_be),
      .local_ready(local_ready), .local_init_done(local_init_done),
      .local_rdata_valid(local_rdata_valid), .local_rdata(local_rdata),
      .tag_count(tag_count), .tag_err(tag_err)
   );

   typedef struct {
      bit          rd;
      logic [24:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
   } txn_t;

   txn_t exp0[$], exp1[$];
   int   tagq[$];      // owners of outstanding reads, oldest first
   int   acc_log[$];   // requester of every accept, in order
   bit   m_err;
   int   owe = -1;     // requester owed the next accept, -1 if none
   int   vecs = 0, errs = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int   m_pre, m_owner, m_k;
   bit   m_oth, m_have;
   txn_t m_t;

   always @(negedge clk) begin
      if (!reset_n) begin
         tagq.delete(); exp0.delete(); exp1.delete();
         m_err = 1'b0;
         owe   = -1;
      end else begin
         m_pre = tagq.size();
         check("tag_count", 64'(tag_count), 64'(m_pre));
         check("tag_err", 64'(tag_err), 64'(m_err));
         check("ready_both", 64'(rq0_ready & rq1_ready), 64'd0);
         check("ready_wo_local_ready", 64'((rq0_ready | rq1_ready) & ~local_ready), 64'd0);
         if (local_rdata_valid) begin
            if (m_pre == 0) begin
               check("empty_pop_valid", 64'({rq1_rdata_valid, rq0_rdata_valid}), 64'd0);
               m_err = 1'b1;
            end else begin
               m_owner = tagq.pop_front();
               check("rdata_owner", 64'({rq1_rdata_valid, rq0_rdata_valid}),
                     (m_owner == 0) ? 64'd1 : 64'd2);
               check("rdata", rq_rdata, local_rdata);
            end
         end else begin
            check("rdata_idle", 64'({rq1_rdata_valid, rq0_rdata_valid}), 64'd0);
         end
         if (rq0_ready || rq1_ready) begin
            m_k   = rq1_ready ? 1 : 0;
            m_oth = (m_k == 0) ? (rq1_read_req | rq1_write_req) : (rq0_read_req | rq0_write_req);
            m_have = (m_k == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
            if (!m_have) begin
               check("spurious_accept", 64'(m_k), 64'hFF);
            end else begin
               if (m_k == 0) m_t = exp0.pop_front();
               else          m_t = exp1.pop_front();
               check("acc_addr", 64'({local_cs_addr, local_row_addr, local_bank_addr, local_col_addr}),
                     64'(m_t.addr));
               if (m_t.rd) begin
                  check("acc_rd", 64'({local_read_req, local_write_req}), 64'd2);
                  check("acc_rd_not_full", 64'(m_pre < 8), 64'd1);
                  tagq.push_back(m_k);
               end else begin
                  check("acc_wr", 64'({local_read_req, local_write_req}), 64'd1);
                  check("acc_wdata", local_wdata, m_t.data);
                  check("acc_be", 64'(local_be), 64'(m_t.be));
               end
            end
            if (owe >= 0) check("rr_order", 64'(m_k), 64'(owe));
            owe = m_oth ? 1 - m_k : -1;
            acc_log.push_back(m_k);
         end
      end
   end

   always @(negedge clk)
      if (reset_n)
         assert (!(rq0_read_req && rq0_write_req) && !(rq1_read_req && rq1_write_req))
            else $error("FAIL bench drove read and write together");

   // ---------------- drivers ----------------
   task automatic set_req(input int k, input bit rd, input logic [24:0] a,
                          input logic [63:0] d, input logic [7:0] be);
      txn_t t;
      t.rd = rd; t.addr = a; t.data = d; t.be = be;
      if (k == 0) begin
         exp0.push_back(t);
         rq0_read_req = rd; rq0_write_req = !rd; rq0_addr = a; rq0_wdata = d; rq0_be = be;
      end else begin
         exp1.push_back(t);
         rq1_read_req = rd; rq1_write_req = !rd; rq1_addr = a; rq1_wdata = d; rq1_be = be;
      end
   endtask

   task automatic clr_req(input int k);
      if (k == 0) begin rq0_read_req = 0; rq0_write_req = 0; end
      else        begin rq1_read_req = 0; rq1_write_req = 0; end
   endtask

   task automatic wait_acc(input int k);
      int  n = 0;
      bit  r;
      do begin
         @(negedge clk);
         n++;
         r = (k == 0) ? rq0_ready : rq1_ready;
      end while (!r && n < 400);
      if (!r) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      clr_req(k);
   endtask

   task automatic issue(input int k, input bit rd);
      set_req(k, rd, 25'($urandom), {$urandom, $urandom}, 8'($urandom));
      wait_acc(k);
   endtask

   task automatic beat(input logic [63:0] d);
      @(posedge clk); #1;
      local_rdata_valid = 1'b1; local_rdata = d;
      @(posedge clk); #1;
      local_rdata_valid = 1'b0;
   endtask

   task automatic rand_drv(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         issue(k, 1'($urandom_range(0, 1)));
      end
   endtask

   // ---------------- main sequence ----------------
   bit d0, d1;
   int base, cyc;

   initial begin
      rq0_read_req = 0; rq0_write_req = 0; rq1_read_req = 0; rq1_write_req = 0;
      rq0_addr = '0; rq1_addr = '0; rq0_wdata = '0; rq1_wdata = '0; rq0_be = '0; rq1_be = '0;
      local_ready = 0; local_init_done = 0; local_rdata_valid = 0; local_rdata = '0;
      reset_n = 1;
      #1 reset_n = 0;
      #1;
      check("rst_local_rd", 64'(local_read_req), 64'd0);
      check("rst_local_wr", 64'(local_write_req), 64'd0);
      check("rst_burstbegin", 64'(local_burstbegin), 64'd0);
      check("rst_ready", 64'({rq1_ready, rq0_ready}), 64'd0);
      check("rst_rvalid", 64'({rq1_rdata_valid, rq0_rdata_valid}), 64'd0);
      check("rst_tag_count", 64'(tag_count), 64'd0);
      check("rst_tag_err", 64'(tag_err), 64'd0);
      check("local_size", 64'(local_size), 64'd1);
      check("local_autopch", 64'(local_autopch_req), 64'd0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1;

      // controller not initialised: no grant out of IDLE
      rq0_write_req = 1; rq0_addr = 25'h1; local_ready = 1;
      repeat (4) begin
         @(negedge clk);
         check("init_low_ready", 64'(rq0_ready), 64'd0);
         check("init_low_wr", 64'(local_write_req), 64'd0);
      end
      @(posedge clk); #1;
      rq0_write_req = 0; local_init_done = 1;
      @(posedge clk); #1;

      // single write, one-cycle grant latency
      set_req(0, 1'b0, 25'h0000123, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF);
      @(negedge clk);
      check("t1_latency_wr", 64'(local_write_req), 64'd0);
      check("t1_latency_ready", 64'(rq0_ready), 64'd0);
      @(negedge clk);
      check("t1_write_req", 64'(local_write_req), 64'd1);
      check("t1_col", 64'(local_col_addr), 64'h123);
      check("t1_ready", 64'(rq0_ready), 64'd1);
      @(posedge clk); #1;
      clr_req(0);
      @(negedge clk);
      @(negedge clk);
      check("t1_released", 64'({local_read_req, local_write_req}), 64'd0);

      // fresh reset so rq0 is preferred, then alternating reads
      @(posedge clk); #2 reset_n = 0;
      @(posedge clk); #2 reset_n = 1;
      @(posedge clk); #1;
      base = acc_log.size();
      fork
         begin issue(0, 1'b1); issue(0, 1'b1); end
         begin issue(1, 1'b1); issue(1, 1'b1); end
      join
      check("t2_accepts", 64'(acc_log.size() - base), 64'd4);
      for (int i = 0; i < 4 && base + i < acc_log.size(); i++)
         check("t2_alternate", 64'(acc_log[base + i]), 64'(i % 2));
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         local_rdata_valid = 1; local_rdata = 64'hD000 + 64'(i);
         @(negedge clk);
         check("t2_beat_owner", 64'({rq1_rdata_valid, rq0_rdata_valid}), (i % 2 == 0) ? 64'd1 : 64'd2);
      end
      @(posedge clk); #1 local_rdata_valid = 0;

      // fill the tag FIFO, 9th read stalls until a pop frees a slot
      for (int i = 0; i < 8; i++) issue(0, 1'b1);
      check("t3_full_count", 64'(tag_count), 64'd8);
      set_req(0, 1'b1, 25'h0ABCDEF, '0, 8'hFF);
      repeat (3) begin
         @(negedge clk);
         check("t3_stall_ready", 64'(rq0_ready), 64'd0);
         check("t3_stall_rd", 64'(local_read_req), 64'd0);
      end
      @(posedge clk); #1;
      local_rdata_valid = 1; local_rdata = 64'h1111_2222_3333_4444;
      @(negedge clk);
      check("t3_pop_cycle_ready", 64'(rq0_ready), 64'd0);
      check("t3_pop_valid", 64'(rq0_rdata_valid), 64'd1);
      @(posedge clk); #1;
      local_rdata_valid = 0;
      @(negedge clk);
      check("t3_ninth_ready", 64'(rq0_ready), 64'd1);
      @(posedge clk); #1;
      clr_req(0);
      check("t3_count_after", 64'(tag_count), 64'd8);
      repeat (5) beat({$urandom, $urandom});

      // push and pop in the same cycle at count 3
      local_ready = 0;
      set_req(1, 1'b1, 25'h1234567, '0, 8'h0F);
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!local_read_req && cyc < 20);
      check("t4_grant", 64'(local_read_req), 64'd1);
      local_ready = 1; local_rdata_valid = 1; local_rdata = 64'hCAFE;
      @(negedge clk);
      check("t4_rq1_ready", 64'(rq1_ready), 64'd1);
      check("t4_pop_rq0", 64'(rq0_rdata_valid), 64'd1);
      @(posedge clk); #1;
      local_rdata_valid = 0;
      clr_req(1);
      check("t4_count", 64'(tag_count), 64'd3);
      repeat (3) beat({$urandom, $urandom});

      // read beat with nothing outstanding
      @(posedge clk); #1;
      local_rdata_valid = 1;
      @(negedge clk);
      check("t5_no_valid", 64'({rq1_rdata_valid, rq0_rdata_valid}), 64'd0);
      @(posedge clk); #1;
      local_rdata_valid = 0;
      @(negedge clk);
      check("t5_err_set", 64'(tag_err), 64'd1);
      repeat (3) @(negedge clk);
      check("t5_err_sticky", 64'(tag_err), 64'd1);

      // async reset mid-grant with 5 tags outstanding
      for (int i = 0; i < 5; i++) issue(0, 1'b1);
      local_ready = 0;
      set_req(0, 1'b0, 25'h0000456, 64'h5, 8'h1);
      repeat (2) @(negedge clk);
      check("t6_grant_pending", 64'(local_write_req), 64'd1);
      @(posedge clk); #2 reset_n = 0;
      #1;
      check("t6_rst_wr", 64'(local_write_req), 64'd0);
      check("t6_rst_rd", 64'(local_read_req), 64'd0);
      check("t6_rst_bb", 64'(local_burstbegin), 64'd0);
      check("t6_rst_ready", 64'({rq1_ready, rq0_ready}), 64'd0);
      check("t6_rst_count", 64'(tag_count), 64'd0);
      check("t6_rst_err", 64'(tag_err), 64'd0);
      clr_req(0);
      local_ready = 1;
      @(posedge clk); #2 reset_n = 1;
      @(posedge clk); #1;

      // randomized traffic with random controller backpressure and returns
      d0 = 0; d1 = 0;
      fork
         begin rand_drv(0, 30); d0 = 1; end
         begin rand_drv(1, 30); d1 = 1; end
         begin
            cyc = 0;
            while (!(d0 && d1 && tagq.size() == 0) && cyc < 20000) begin
               @(posedge clk); #1;
               local_ready       = ($urandom_range(0, 3) != 0);
               local_rdata_valid = (tagq.size() > 0) && ($urandom_range(0, 2) == 0);
               local_rdata       = {$urandom, $urandom};
               cyc++;
            end
            if (cyc >= 20000) check("drain_timeout", 64'd0, 64'd1);
            local_rdata_valid = 0;
            local_ready       = 1;
         end
      join
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
